approx_mult_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's combinational quadrant-split approximate multipliers.
- Splits two W-bit unsigned operands into halves and forms four (W/2)x(W/2) quadrant products.
- Each quadrant is selected exact or approximate per transaction by a runtime mode mask, not fixed at elaboration.
- Recombines the quadrant products into a 2W-bit result behind a 3-stage valid/ready pipeline with backpressure; sits between operand sources and accuracy-evaluation logic.

---
 rtl/approx_mult_pipe.sv | 117 +++++++++++
 tb/tb_approx_mult_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_pipe.sv
// Pipelined quadrant-split approximate multiplier with per-beat exact/approximate quadrant selection.
// Define ERR_MON_EN to add a saturating counter of inexact results (err_cnt port, ERR_W parameter).
module approx_mult_pipe #(
  parameter int unsigned W     = 8,
  parameter int unsigned TRUNC = 2
`ifdef ERR_MON_EN
  ,
  parameter int unsigned ERR_W = 16
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [3:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] r
`ifdef ERR_MON_EN
  ,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  localparam int unsigned H  = W / 2;
  localparam int unsigned PW = 2 * H;
  localparam int unsigned RW = 2 * W;
  localparam logic [H-1:0] KEEP = ~H'((1 << TRUNC) - 1);

  // One quadrant product; approximate quadrants drop the low TRUNC bits of both halves.
  function automatic logic [PW-1:0] qmul(input logic [H-1:0] x, input logic [H-1:0] y,
                                         input logic approx);
    logic [H-1:0] xs;
    logic [H-1:0] ys;
    xs = approx ? (x & KEEP) : x;
    ys = approx ? (y & KEEP) : y;
    return PW'(xs) * PW'(ys);
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic           s1_valid;
  logic [W-1:0]   a1;
  logic [W-1:0]   b1;
  logic [3:0]     m1;
  logic           s2_valid;
  logic [PW-1:0]  pq0;
  logic [PW-1:0]  pq1;
  logic [PW-1:0]  pq2;
  logic [PW-1:0]  pq3;
  logic [RW-1:0]  sum;

  // Valid bits: all stages advance together on adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  // Stage 1/2 payload needs no reset; it is qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (adv) begin
      a1  <= a;
      b1  <= b;
      m1  <= mode;
      pq0 <= qmul(a1[H-1:0], b1[H-1:0], m1[0]);
      pq1 <= qmul(a1[H-1:0], b1[W-1:H], m1[1]);
      pq2 <= qmul(a1[W-1:H], b1[H-1:0], m1[2]);
      pq3 <= qmul(a1[W-1:H], b1[W-1:H], m1[3]);
    end
  end

  assign sum = RW'(pq0) + (RW'(pq1) << H) + (RW'(pq2) << H) + (RW'(pq3) << W);

  // r only changes when a valid beat moves into the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
    end else if (adv && s2_valid) begin
      r <= sum;
    end
  end

`ifdef ERR_MON_EN
  logic [RW-1:0] exact2;
  logic [RW-1:0] exact3;

  always_ff @(posedge clk) begin
    if (adv) begin
      exact2 <= RW'(a1) * RW'(b1);
      if (s2_valid) begin
        exact3 <= exact2;
      end
    end
  end

  // Count inexact results as they are consumed, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && (r != exact3) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe (W=8, TRUNC=2): vector table, scoreboard, backpressure,
// streaming and mid-flight reset sequences.
module tb_approx_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] r;
`ifdef ERR_MON_EN
  logic [15:0] err_cnt;
  int          exp_err = 0;
  bit          inexq[$];
`endif

  int          checks = 0;
  int          passed = 0;
  int          nout   = 0;
  logic [15:0] expq[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  mode;
    logic [15:0] r;
  } vec_t;

  localparam int NV = 9;
  vec_t tbl[NV];

  approx_mult_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r)
`ifdef ERR_MON_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: 4-bit halves, approximate quadrants clear the two low bits of each half.
  function automatic logic [7:0] q(input logic [3:0] x, input logic [3:0] y, input logic ap);
    logic [3:0] xs;
    logic [3:0] ys;
    xs = ap ? (x & 4'b1100) : x;
    ys = ap ? (y & 4'b1100) : y;
    return 8'(xs) * 8'(ys);
  endfunction

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic [3:0] m);
    return 16'(q(x[3:0], y[3:0], m[0]))
         + (16'(q(x[3:0], y[7:4], m[1])) << 4)
         + (16'(q(x[7:4], y[3:0], m[2])) << 4)
         + (16'(q(x[7:4], y[7:4], m[3])) << 8);
  endfunction

  // Scoreboard: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
`ifdef ERR_MON_EN
      inexq.delete();
      exp_err = 0;
`endif
    end else begin
      if (out_valid && out_ready) begin
        nout++;
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL sb_unexpected: got r=%0d, expected no output", r);
        end else begin
          check("sb_r", 32'(r), 32'(expq.pop_front()));
`ifdef ERR_MON_EN
          if (inexq.pop_front()) exp_err++;
`endif
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, mode));
`ifdef ERR_MON_EN
        inexq.push_back(model(a, b, mode) != 16'(a) * 16'(b));
`endif
      end
    end
  end

  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vm,
                      output int waited);
    a = va; b = vb; mode = vm; in_valid = 1'b1; waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    int base;
    int stalls;

    tbl[0] = '{8'hFF, 8'hFF, 4'h0, 16'd65025};
    tbl[1] = '{8'hFF, 8'hFF, 4'hF, 16'd41616};
    tbl[2] = '{8'hFF, 8'hFF, 4'h3, 16'd63648};
    tbl[3] = '{8'h34, 8'h56, 4'h0, 16'd4472};
    tbl[4] = '{8'hFF, 8'hFF, 4'h8, 16'd44289};
    tbl[5] = '{8'h13, 8'h27, 4'h1, 16'd720};
    tbl[6] = '{8'h13, 8'h27, 4'h0, 16'd741};
    tbl[7] = '{8'h80, 8'h02, 4'hF, 16'd0};
    tbl[8] = '{8'h00, 8'hFF, 4'hF, 16'd0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; mode = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_r", 32'(r), 0);
`ifdef ERR_MON_EN
    check("rst_err_cnt", 32'(err_cnt), 0);
`endif

    // Single beats: latency, value, and release after handshake.
    @(posedge clk); #1;
    for (int i = 0; i < NV; i++) begin
      int lat;
      a = tbl[i].a; b = tbl[i].b; mode = tbl[i].mode; in_valid = 1'b1;
      @(negedge clk);
      check("vec_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      check("vec_latency", 32'(lat), 3);
      check("vec_r", 32'(r), 32'(tbl[i].r));
      @(posedge clk); #1;
      check("vec_release", 32'(out_valid), 0);
    end

    // Backpressure: fill the pipe with out_ready low, then release.
    out_ready = 1'b0;
    base = nout;
    fork
      begin
        for (int k = 1; k <= 4; k++) send(8'(k), 8'd3, 4'd0, w);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("bp_valid", 32'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
          check("bp_hold_r", 32'(r), 3);
          check("bp_in_ready", 32'(in_ready), 0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("bp_count", 32'(nout - base), 4);

    // Full-rate stream with random modes.
    base = nout;
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), w);
      stalls += w;
    end
    repeat (5) @(posedge clk);
    #1;
    check("stream_stalls", 32'(stalls), 0);
    check("stream_count", 32'(nout - base), 20);
`ifdef ERR_MON_EN
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif

    // Reset with two beats in flight: neither may emerge.
    send(8'hFF, 8'hFF, 4'hF, w);
    send(8'h34, 8'h56, 4'h0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_r", 32'(r), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
`ifdef ERR_MON_EN
    check("midrst_err_cnt", 32'(err_cnt), 0);
`endif
    base = nout;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_output", 32'(nout - base), 0);

    // Recovery after reset.
    send(8'h13, 8'h27, 4'h1, w);
    repeat (5) @(posedge clk);
    #1;
    check("recover_count", 32'(nout - base), 1);
    check("recover_r", 32'(r), 720);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
